// File: rtl/cfa_pkg.sv
// Shared defaults, widths and the loader state encoding for the raw-frame
// capture path feeding the demosaic (CFA) stage.
package cfa_pkg;

  localparam int PIX_W_DEF  = 12;
  localparam int ADDR_W_DEF = 17;
  localparam int DIM_W      = 11;
  localparam int PROD_W     = 2 * DIM_W;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LOAD     = 2'd1,
    ST_KICK     = 2'd2,
    ST_WAIT_CFA = 2'd3
  } loader_state_t;

  // Full-width product so the largest 11x11-bit frame cannot wrap.
  function automatic logic [PROD_W-1:0] frame_size(input logic [DIM_W-1:0] rows,
                                                   input logic [DIM_W-1:0] cols);
    return PROD_W'(rows) * PROD_W'(cols);
  endfunction

endpackage

// File: rtl/raw_addr_counter.sv
// Row/column/linear address counter for raster-order frame writes.
// load restarts at pixel 0; load together with inc consumes pixel 0 at once.
module raw_addr_counter
  import cfa_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              inc,
  input  logic [DIM_W-1:0]  row_max,
  input  logic [DIM_W-1:0]  col_max,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [DIM_W-1:0] row;
  logic [DIM_W-1:0] col;
  logic [DIM_W-1:0] row_lim;
  logic [DIM_W-1:0] col_lim;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row     <= '0;
      col     <= '0;
      row_lim <= '0;
      col_lim <= '0;
      addr    <= '0;
    end else if (load) begin
      row_lim <= row_max;
      col_lim <= col_max;
      if (inc) begin
        // single-column frames wrap straight onto the next row
        if (col_max == DIM_W'(1)) begin
          col <= '0;
          row <= DIM_W'(1);
        end else begin
          col <= DIM_W'(1);
          row <= '0;
        end
        addr <= ADDR_W'(1);
      end else begin
        row  <= '0;
        col  <= '0;
        addr <= '0;
      end
    end else if (inc) begin
      if (col == col_lim - DIM_W'(1)) begin
        col <= '0;
        row <= row + DIM_W'(1);
      end else begin
        col <= col + DIM_W'(1);
      end
      addr <= addr + ADDR_W'(1);
    end
  end

  assign last = (row == row_lim - DIM_W'(1)) && (col == col_lim - DIM_W'(1));

endmodule

// File: rtl/raw_frame_loader.sv
// Streams one raw Bayer frame into frame memory, then kicks the demosaic stage.
// Optional RAW_BLACK_LEVEL_EN adds a saturating black-level subtract on write data.
//
// state       | meaning
// ST_IDLE     | waiting for a pix_sof pixel; non-sof pixels are dropped
// ST_LOAD     | writing pixels in raster order
// ST_KICK     | frame complete; cfaStart pulses on the following cycle
// ST_WAIT_CFA | waiting for cfaDone from the demosaic stage
module raw_frame_loader
  import cfa_pkg::*;
#(
  parameter int PIX_W  = PIX_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DIM_W-1:0]  rowMax,
  input  logic [DIM_W-1:0]  colMax,
  input  logic              pix_valid,
  input  logic              pix_sof,
  input  logic [PIX_W-1:0]  pix_data,
`ifdef RAW_BLACK_LEVEL_EN
  input  logic [PIX_W-1:0]  blackLevel,
`endif
  output logic              pix_ready,
  output logic [ADDR_W-1:0] rawWriteAddress,
  output logic              rawWriteEnable,
  output logic [PIX_W-1:0]  rawWriteData,
  output logic              cfaStart,
  input  logic              cfaDone,
  output logic              busy,
  output logic              frameError
);

  localparam logic [PROD_W:0] ADDR_SPAN = {{PROD_W{1'b0}}, 1'b1} << ADDR_W;

  loader_state_t     state;
  loader_state_t     state_nxt;
  logic [PROD_W-1:0] frame_total;
  logic              cfg_ok;
  logic              accept;
  logic              sof_acc;
  logic              start_frame;
  logic              data_acc;
  logic              do_write;
  logic              pix_last;
  logic              cnt_last;
  logic [ADDR_W-1:0] cnt_addr;
  logic [PIX_W-1:0]  pix_adj;
  logic              cfa_start_d;

  assign frame_total = frame_size(rowMax, colMax);
  assign cfg_ok      = (rowMax != '0) && (colMax != '0) && ({1'b0, frame_total} <= ADDR_SPAN);

  assign accept      = pix_valid && pix_ready;
  assign sof_acc     = accept && pix_sof;
  assign start_frame = sof_acc && cfg_ok;
  assign data_acc    = accept && !pix_sof && (state == ST_LOAD);
  assign do_write    = start_frame || data_acc;
  // the sof pixel is the whole frame only for a 1x1 geometry
  assign pix_last    = start_frame ? (frame_total == PROD_W'(1)) : cnt_last;

`ifdef RAW_BLACK_LEVEL_EN
  assign pix_adj = (pix_data > blackLevel) ? (pix_data - blackLevel) : '0;
`else
  assign pix_adj = pix_data;
`endif

  raw_addr_counter #(
    .ADDR_W (ADDR_W)
  ) u_addr_counter (
    .clk     (clk),
    .rst     (rst),
    .load    (start_frame),
    .inc     (do_write),
    .row_max (rowMax),
    .col_max (colMax),
    .addr    (cnt_addr),
    .last    (cnt_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_LOAD: begin
        if (do_write && pix_last) begin
          state_nxt = ST_KICK;
        end else if (start_frame) begin
          state_nxt = ST_LOAD;
        end else if (sof_acc) begin
          // bad geometry on a sof abandons any frame in progress
          state_nxt = ST_IDLE;
        end
      end
      ST_KICK:     state_nxt = cfaDone ? ST_IDLE : ST_WAIT_CFA;
      ST_WAIT_CFA: if (cfaDone) state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    pix_ready   = 1'b0;
    busy        = 1'b0;
    cfa_start_d = 1'b0;
    case (state)
      ST_IDLE:     pix_ready = rst;
      ST_LOAD: begin
        pix_ready = rst;
        busy      = 1'b1;
      end
      ST_KICK: begin
        busy        = 1'b1;
        cfa_start_d = 1'b1;
      end
      ST_WAIT_CFA: busy = 1'b1;
      default: begin
        pix_ready   = 1'b0;
        busy        = 1'b0;
        cfa_start_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rawWriteEnable  <= 1'b0;
      rawWriteAddress <= '0;
      rawWriteData    <= '0;
      cfaStart        <= 1'b0;
      frameError      <= 1'b0;
    end else begin
      rawWriteEnable <= do_write;
      if (do_write) begin
        rawWriteAddress <= start_frame ? '0 : cnt_addr;
        rawWriteData    <= pix_adj;
      end
      cfaStart <= cfa_start_d;
      if (sof_acc) begin
        frameError <= !cfg_ok || (state == ST_LOAD);
      end
    end
  end

endmodule

// File: tb/tb_raw_frame_loader.sv
// Self-checking bench for raw_frame_loader: expected writes are queued as
// pixels are driven and compared as rawWriteEnable strobes appear.
module tb_raw_frame_loader;

  logic        clk;
  logic        rst;
  logic [10:0] rowMax;
  logic [10:0] colMax;
  logic        pix_valid;
  logic        pix_sof;
  logic [11:0] pix_data;
  logic        pix_ready;
  logic [16:0] rawWriteAddress;
  logic        rawWriteEnable;
  logic [11:0] rawWriteData;
  logic        cfaStart;
  logic        cfaDone;
  logic        busy;
  logic        frameError;
`ifdef RAW_BLACK_LEVEL_EN
  logic [11:0] blackLevel;
`endif

  raw_frame_loader #(.PIX_W(12), .ADDR_W(17)) dut (
    .clk             (clk),
    .rst             (rst),
    .rowMax          (rowMax),
    .colMax          (colMax),
    .pix_valid       (pix_valid),
    .pix_sof         (pix_sof),
    .pix_data        (pix_data),
`ifdef RAW_BLACK_LEVEL_EN
    .blackLevel      (blackLevel),
`endif
    .pix_ready       (pix_ready),
    .rawWriteAddress (rawWriteAddress),
    .rawWriteEnable  (rawWriteEnable),
    .rawWriteData    (rawWriteData),
    .cfaStart        (cfaStart),
    .cfaDone         (cfaDone),
    .busy            (busy),
    .frameError      (frameError)
  );

  typedef struct {
    logic [16:0] addr;
    logic [11:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   wr_count = 0;
  int   cfa_count = 0;
  int   last_wr_cyc = 0;
  int   cfa_cyc  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Scoreboard: every write must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rawWriteEnable) begin
      wr_count++;
      last_wr_cyc = cyc;
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL write_unexpected: got addr %0d data %0d, required no write",
                 rawWriteAddress, rawWriteData);
      end else begin
        e = exp_q.pop_front();
        if (rawWriteAddress !== e.addr || rawWriteData !== e.data)
          $display("FAIL write_match: got addr %0d data %0d, required addr %0d data %0d",
                   rawWriteAddress, rawWriteData, e.addr, e.data);
        else
          n_pass++;
      end
    end
    if (cfaStart) begin
      cfa_count++;
      cfa_cyc = cyc;
    end
  end

  function automatic logic [11:0] pix_val(input int i, input int base);
    int v;
    v = (i * 53 + base) % 4096;
    return v[11:0];
  endfunction

  function automatic logic [11:0] exp_data(input logic [11:0] p);
`ifdef RAW_BLACK_LEVEL_EN
    return (p > blackLevel) ? p - blackLevel : 12'd0;
`else
    return p;
`endif
  endfunction

  task automatic drive_pix(input logic sof, input logic [11:0] d, input int a, input bit expect_wr);
    @(negedge clk);
    pix_valid = 1'b1;
    pix_sof   = sof;
    pix_data  = d;
    cfaDone   = 1'b0;
    if (expect_wr) exp_q.push_back('{addr: 17'(a), data: exp_data(d)});
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      pix_valid = 1'b0;
      pix_sof   = 1'b0;
      cfaDone   = 1'b0;
    end
  endtask

  task automatic stream_frame(input int rows, input int cols, input bit gapped,
                              input int base, input int done_at);
    rowMax = 11'(rows);
    colMax = 11'(cols);
    for (int i = 0; i < rows * cols; i++) begin
      drive_pix(i == 0, pix_val(i, base), i, 1'b1);
      if (gapped) begin
        @(negedge clk);
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        cfaDone   = (i == done_at);
      end
    end
    idle_cycles(1);
  endtask

  task automatic finish_cfa();
    @(negedge clk);
    cfaDone = 1'b1;
    @(negedge clk);
    cfaDone = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({rawWriteEnable, cfaStart, busy, frameError, pix_ready} !== 5'b0)
      $display("FAIL reset_flags: got we/cs/busy/err/rdy %b, required 00000",
               {rawWriteEnable, cfaStart, busy, frameError, pix_ready});
    else n_pass++;
    n_checks++;
    if (rawWriteAddress !== 17'd0 || rawWriteData !== 12'd0)
      $display("FAIL reset_bus: got addr %0d data %0d, required 0 0", rawWriteAddress, rawWriteData);
    else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (pix_ready !== 1'b1) $display("FAIL reset_release_ready: got %b, required 1", pix_ready);
    else n_pass++;
  endtask

  task automatic check_frame_done(input string tag, input int wr0, input int cf0, input int nwr);
    idle_cycles(4);
    n_checks++;
    if (wr_count - wr0 !== nwr || exp_q.size() != 0)
      $display("FAIL %s_writes: got %0d writes (%0d pending), required %0d", tag, wr_count - wr0, exp_q.size(), nwr);
    else n_pass++;
    n_checks++;
    if (cfa_count - cf0 !== 1) $display("FAIL %s_cfastart_count: got %0d, required 1", tag, cfa_count - cf0);
    else n_pass++;
    n_checks++;
    if (cfa_cyc !== last_wr_cyc + 1)
      $display("FAIL %s_cfastart_timing: got cycle %0d, required %0d", tag, cfa_cyc, last_wr_cyc + 1);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b1 || pix_ready !== 1'b0)
      $display("FAIL %s_wait_busy: got busy %b ready %b, required 1 0", tag, busy, pix_ready);
    else n_pass++;
    finish_cfa();
    n_checks++;
    if (busy !== 1'b0 || pix_ready !== 1'b1)
      $display("FAIL %s_after_done: got busy %b ready %b, required 0 1", tag, busy, pix_ready);
    else n_pass++;
  endtask

  task automatic test_continuous();
    int wr0 = wr_count;
    int cf0 = cfa_count;
    stream_frame(7, 7, 1'b0, 5, -1);
    check_frame_done("cont", wr0, cf0, 49);
  endtask

  task automatic test_idle_drop();
    int wr0 = wr_count;
    for (int i = 0; i < 3; i++) drive_pix(1'b0, pix_val(i, 9), 0, 1'b0);
    idle_cycles(3);
    n_checks++;
    if (wr_count - wr0 !== 0 || busy !== 1'b0)
      $display("FAIL idle_drop: got %0d writes busy %b, required 0 0", wr_count - wr0, busy);
    else n_pass++;
  endtask

  task automatic test_gapped();
    int wr0 = wr_count;
    int cf0 = cfa_count;
    stream_frame(7, 7, 1'b1, 5, 10);
    check_frame_done("gap", wr0, cf0, 49);
  endtask

  task automatic test_restart();
    int wr0 = wr_count;
    int cf0 = cfa_count;
    rowMax = 11'd7;
    colMax = 11'd7;
    for (int i = 0; i < 20; i++) drive_pix(i == 0, pix_val(i, 1), i, 1'b1);
    drive_pix(1'b1, pix_val(0, 700), 0, 1'b1);
    for (int i = 1; i < 49; i++) begin
      drive_pix(1'b0, pix_val(i, 700), i, 1'b1);
      if (i == 1) begin
        n_checks++;
        if (frameError !== 1'b1) $display("FAIL restart_error: got %b, required 1", frameError);
        else n_pass++;
      end
    end
    idle_cycles(1);
    check_frame_done("restart", wr0, cf0, 69);
    n_checks++;
    if (frameError !== 1'b1) $display("FAIL restart_error_sticky: got %b, required 1", frameError);
    else n_pass++;
  endtask

  task automatic test_kick_done();
    int wr0 = wr_count;
    int cf0 = cfa_count;
    rowMax = 11'd2;
    colMax = 11'd2;
    for (int i = 0; i < 4; i++) drive_pix(i == 0, pix_val(i, 33), i, 1'b1);
    @(negedge clk);
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    cfaDone   = 1'b1;
    @(negedge clk);
    cfaDone = 1'b0;
    idle_cycles(2);
    n_checks++;
    if (busy !== 1'b0 || cfa_count - cf0 !== 1)
      $display("FAIL kick_done: got busy %b cfastarts %0d, required 0 1", busy, cfa_count - cf0);
    else n_pass++;
    n_checks++;
    if (wr_count - wr0 !== 4 || exp_q.size() != 0)
      $display("FAIL kick_writes: got %0d, required 4", wr_count - wr0);
    else n_pass++;
    n_checks++;
    if (frameError !== 1'b0) $display("FAIL error_cleared: got %b, required 0", frameError);
    else n_pass++;
  endtask

  task automatic test_bad_cfg();
    int wr0 = wr_count;
    rowMax = 11'd0;
    colMax = 11'd7;
    drive_pix(1'b1, 12'd100, 0, 1'b0);
    idle_cycles(2);
    n_checks++;
    if (frameError !== 1'b1 || pix_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL bad_rows: got err %b ready %b busy %b, required 1 1 0", frameError, pix_ready, busy);
    else n_pass++;
    rowMax = 11'd400;
    colMax = 11'd400;
    drive_pix(1'b1, 12'd100, 0, 1'b0);
    idle_cycles(2);
    n_checks++;
    if (frameError !== 1'b1 || busy !== 1'b0 || wr_count - wr0 !== 0)
      $display("FAIL bad_oversize: got err %b busy %b writes %0d, required 1 0 0", frameError, busy, wr_count - wr0);
    else n_pass++;
    rowMax = 11'd256;
    colMax = 11'd512;
    drive_pix(1'b1, 12'd77, 0, 1'b1);
    idle_cycles(2);
    n_checks++;
    if (frameError !== 1'b0 || busy !== 1'b1)
      $display("FAIL full_span_accepted: got err %b busy %b, required 0 1", frameError, busy);
    else n_pass++;
    #2 rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int wr0;
    int cf0 = cfa_count;
    rowMax = 11'd7;
    colMax = 11'd7;
    for (int i = 0; i < 30; i++) drive_pix(i == 0, pix_val(i, 200), i, 1'b1);
    @(negedge clk);
    pix_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({rawWriteEnable, cfaStart, busy, frameError, pix_ready} !== 5'b0 ||
        rawWriteAddress !== 17'd0 || rawWriteData !== 12'd0)
      $display("FAIL midreset_outputs: got we/cs/busy/err/rdy %b addr %0d data %0d, required all 0",
               {rawWriteEnable, cfaStart, busy, frameError, pix_ready}, rawWriteAddress, rawWriteData);
    else n_pass++;
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL midreset_pending: got %0d, required 0", exp_q.size());
    else n_pass++;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (pix_ready !== 1'b1 || cfa_count - cf0 !== 0)
      $display("FAIL midreset_release: got ready %b cfastarts %0d, required 1 0", pix_ready, cfa_count - cf0);
    else n_pass++;
    wr0 = wr_count;
    cf0 = cfa_count;
    stream_frame(7, 7, 1'b0, 900, -1);
    check_frame_done("post_reset", wr0, cf0, 49);
  endtask

`ifdef RAW_BLACK_LEVEL_EN
  task automatic test_black_level();
    int wr0 = wr_count;
    blackLevel = 12'd64;
    rowMax = 11'd1;
    colMax = 11'd2;
    drive_pix(1'b1, 12'd10, 0, 1'b0);
    exp_q.push_back('{addr: 17'd0, data: 12'd0});
    drive_pix(1'b0, 12'd100, 1, 1'b0);
    exp_q.push_back('{addr: 17'd1, data: 12'd36});
    idle_cycles(3);
    n_checks++;
    if (wr_count - wr0 !== 2 || exp_q.size() != 0)
      $display("FAIL black_level_writes: got %0d, required 2", wr_count - wr0);
    else n_pass++;
    finish_cfa();
    blackLevel = 12'd0;
  endtask
`endif

  initial begin
    rowMax    = 11'd0;
    colMax    = 11'd0;
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    pix_data  = 12'd0;
    cfaDone   = 1'b0;
`ifdef RAW_BLACK_LEVEL_EN
    blackLevel = 12'd0;
`endif
    test_reset();
    test_continuous();
    test_idle_drop();
    test_gapped();
    test_restart();
    test_kick_done();
    test_bad_cfg();
    test_reset_mid();
`ifdef RAW_BLACK_LEVEL_EN
    test_black_level();
`endif
    idle_cycles(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
